// File: rtl/alu_sequencer.sv
// ALU initiator: takes one op per request handshake, drives the ALU
// operand registers and returns the captured result on a response channel.
module alu_sequencer #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_func,
  input  logic             req_chain,
  input  logic             req_keep_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [WIDTH-1:0] alu_in_a,
  output logic [WIDTH-1:0] alu_in_b,
  output logic             alu_wren_a,
  output logic             alu_wren_b,
  output logic [3:0]       alu_func,
  input  logic [WIDTH-1:0] alu_result,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXEC,
    RESP
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] last_result;
  logic             accept;
  logic             rsp_fire;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_ready && req_valid;
  assign rsp_fire  = (state_q == RESP) && rsp_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_valid) state_d = LOAD;
      LOAD: state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_result <= '0;
      op_count    <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_tag     <= '0;
      alu_in_a    <= '0;
      alu_in_b    <= '0;
      alu_wren_a  <= 1'b0;
      alu_wren_b  <= 1'b0;
      alu_func    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_in_a   <= req_chain ? last_result : req_a;
        alu_in_b   <= req_b;
        alu_wren_a <= 1'b1;
        alu_wren_b <= ~req_keep_b;
        alu_func   <= req_func;
        rsp_tag    <= req_tag;
      end
      // ALU samples operands at the edge closing LOAD
      if (state_q == LOAD) begin
        alu_wren_a <= 1'b0;
        alu_wren_b <= 1'b0;
      end
      if (state_q == EXEC) begin
        rsp_result  <= alu_result;
        last_result <= alu_result;
        rsp_valid   <= 1'b1;
        if (op_count != {CNT_W{1'b1}})
          op_count <= op_count + 1'b1;
      end
      if (rsp_fire)
        rsp_valid <= 1'b0;
    end
  end

endmodule
